// File: rtl/xosera_bus_pkg.sv
// Shared types and helpers for the Xosera 8-bit register bus initiator.
package xosera_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } bus_state_t;

  localparam logic BYTESEL_EVEN = 1'b0;
  localparam logic BYTESEL_ODD  = 1'b1;

  // Counter must hold the largest phase length minus one.
  function automatic int phase_cnt_width(input int s, input int t, input int h);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/xosera_bus_master_if.sv
// Command/response handshake plus Xosera byte bus, seen from the initiator (master) or its environment (slave).
// Handshake: a command transfers on a clock edge where cmd_valid_i && cmd_ready_o; rsp_valid_o is a one-cycle completion pulse.
interface xosera_bus_master_if;
  import xosera_bus_pkg::*;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_i;
  logic        cmd_byte_i;
  logic        cmd_bytesel_i;
  logic [3:0]  cmd_reg_i;
  logic [15:0] cmd_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        bus_cs_n_o;
  logic        bus_rd_nwr_o;
  logic        bus_bytesel_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe_o;
  logic [7:0]  bus_data_i;
  bus_state_t  dbg_state;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_byte_i, cmd_bytesel_i, cmd_reg_i, cmd_data_i, bus_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
           bus_reg_num_o, bus_data_o, bus_data_oe_o, dbg_state
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_byte_i, cmd_bytesel_i, cmd_reg_i, cmd_data_i, bus_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o,
           bus_reg_num_o, bus_data_o, bus_data_oe_o, dbg_state
  );

endinterface

// File: rtl/xosera_bus_phase_cnt.sv
// Loadable down-counter timing the SETUP, STROBE and HOLD phases; stops at zero.
module xosera_bus_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/xosera_bus_master.sv
// Serialises 16-bit register read/write commands into one or two timed byte strobes on the Xosera bus.
module xosera_bus_master
  import xosera_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input logic                clk,
  input logic                reset_i,
  xosera_bus_master_if.master bus
);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
    $error("xosera_bus_master: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
  end

  localparam int PW = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [PW-1:0] SETUP_LOAD  = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] STROBE_LOAD = PW'(STROBE_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LOAD   = PW'(HOLD_CYCLES - 1);

  function automatic logic [7:0] lane_of(input logic [15:0] d, input logic sel);
    return (sel == BYTESEL_ODD) ? d[7:0] : d[15:8];
  endfunction

  bus_state_t    state, state_next;
  logic          cnt_load, cnt_zero;
  logic [PW-1:0] cnt_val;
  logic          accept, last_byte, sample, next_byte, finish, first_bsel;

  logic          ready_q, wr_q, word_q, second_q;
  logic [7:0]    data_lo_q;
  logic [15:0]   rd_buf;
  logic          cs_n_q, rd_nwr_q, bsel_q, oe_q, rsp_valid_q;
  logic [3:0]    reg_q;
  logic [7:0]    dout_q;
  logic [15:0]   rsp_data_q;

  xosera_bus_phase_cnt #(.W(PW)) u_phase_cnt (
    .clk      (clk),
    .reset_i  (reset_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // ready_q is only ever set when the FSM is heading into IDLE.
  assign accept     = ready_q && bus.cmd_valid_i;
  assign last_byte  = !word_q || second_q;
  assign sample     = (state == STROBE) && cnt_zero && !wr_q;
  assign next_byte  = (state == HOLD) && cnt_zero && !last_byte;
  assign finish     = (state == HOLD) && cnt_zero && last_byte;
  assign first_bsel = bus.cmd_byte_i ? bus.cmd_bytesel_i : BYTESEL_EVEN;

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = SETUP_LOAD;
    case (state)
      IDLE:   if (accept)   begin state_next = SETUP;  cnt_load = 1'b1; cnt_val = SETUP_LOAD;  end
      SETUP:  if (cnt_zero) begin state_next = STROBE; cnt_load = 1'b1; cnt_val = STROBE_LOAD; end
      STROBE: if (cnt_zero) begin state_next = HOLD;   cnt_load = 1'b1; cnt_val = HOLD_LOAD;   end
      HOLD: begin
        if (cnt_zero) begin
          if (last_byte) begin
            state_next = IDLE;
          end else begin
            state_next = SETUP;
            cnt_load   = 1'b1;
            cnt_val    = SETUP_LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data only move on SETUP entry, so cs_n can never fall alongside a change.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      word_q      <= 1'b0;
      second_q    <= 1'b0;
      data_lo_q   <= 8'h00;
      rd_buf      <= 16'h0000;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      bsel_q      <= BYTESEL_EVEN;
      reg_q       <= 4'h0;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      ready_q     <= (state_next == IDLE);
      cs_n_q      <= (state_next != STROBE);
      rsp_valid_q <= finish;
      if (accept) begin
        wr_q      <= bus.cmd_wr_i;
        word_q    <= !bus.cmd_byte_i;
        second_q  <= 1'b0;
        data_lo_q <= bus.cmd_data_i[7:0];
        rd_buf    <= 16'h0000;
        reg_q     <= bus.cmd_reg_i;
        rd_nwr_q  <= !bus.cmd_wr_i;
        bsel_q    <= first_bsel;
        dout_q    <= bus.cmd_wr_i ? lane_of(bus.cmd_data_i, first_bsel) : 8'h00;
        oe_q      <= bus.cmd_wr_i;
      end
      if (sample) begin
        if (bsel_q == BYTESEL_ODD) rd_buf[7:0]  <= bus.bus_data_i;
        else                       rd_buf[15:8] <= bus.bus_data_i;
      end
      if (next_byte) begin
        second_q <= 1'b1;
        bsel_q   <= BYTESEL_ODD;
        dout_q   <= wr_q ? data_lo_q : 8'h00;
      end
      if (finish) begin
        oe_q       <= 1'b0;
        rd_nwr_q   <= 1'b1;
        rsp_data_q <= rd_buf;
      end
    end
  end

  assign bus.cmd_ready_o   = ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.bus_cs_n_o    = cs_n_q;
  assign bus.bus_rd_nwr_o  = rd_nwr_q;
  assign bus.bus_bytesel_o = bsel_q;
  assign bus.bus_reg_num_o = reg_q;
  assign bus.bus_data_o    = dout_q;
  assign bus.bus_data_oe_o = oe_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_xosera_bus_master.sv
// Directed bench for xosera_bus_master: command table against a Xosera register model, plus timing/corner sequences.
module tb_xosera_bus_master;
  import xosera_bus_pkg::*;

  localparam int A_S = 1;
  localparam int A_T = 2;
  localparam int A_H = 1;

  typedef struct {
    logic        wr;
    logic        byte_acc;
    logic        bsel;
    logic [3:0]  regn;
    logic [15:0] data;
    logic [15:0] exp_rsp;
    int          exp_lat;
  } cmd_vec_t;

  typedef struct {
    logic       cs_n;
    logic       oe;
    logic       rsp;
    logic       rd_nwr;
    logic       bsel;
    logic [7:0] data;
  } trace_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  xosera_bus_master_if bus_a ();
  xosera_bus_master_if bus_b ();

  xosera_bus_master #(.SETUP_CYCLES(A_S), .STROBE_CYCLES(A_T), .HOLD_CYCLES(A_H)) dut_a (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus_a)
  );

  xosera_bus_master dut_b (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] reg_model[16];
  bit   model_init = 1'b0;
  int   low_cnt = 0;
  int   high_cnt = 1000;
  logic prev_cs_n = 1'b1;
  logic [14:0] prev_snap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Xosera register model: writes land and reads are valid only in the last strobe cycle.
  always @(negedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < 16; i++) reg_model[i] = 16'h0000;
      reg_model[11] = 16'h1234;
      model_init = 1'b1;
    end
    if (bus_a.bus_cs_n_o === 1'b0) low_cnt++;
    else                           low_cnt = 0;
    bus_a.bus_data_i = 8'hEE;
    if (bus_a.bus_cs_n_o === 1'b0 && low_cnt == A_T) begin
      if (!bus_a.bus_rd_nwr_o) begin
        if (bus_a.bus_bytesel_o) reg_model[bus_a.bus_reg_num_o][7:0]  = bus_a.bus_data_o;
        else                     reg_model[bus_a.bus_reg_num_o][15:8] = bus_a.bus_data_o;
      end else begin
        bus_a.bus_data_i = bus_a.bus_bytesel_o ? reg_model[bus_a.bus_reg_num_o][7:0]
                                               : reg_model[bus_a.bus_reg_num_o][15:8];
      end
    end
  end

  // Protocol checker: nothing moves while cs_n is low, and cs_n stays high long enough between strobes.
  always @(negedge clk) begin
    logic [14:0] snap;
    snap = {bus_a.bus_reg_num_o, bus_a.bus_rd_nwr_o, bus_a.bus_bytesel_o, bus_a.bus_data_o, bus_a.bus_data_oe_o};
    if (bus_a.bus_cs_n_o === 1'b0) begin
      check("stable_in_strobe", 32'(snap), 32'(prev_snap));
      check("oe_vs_dir", 32'(bus_a.bus_data_oe_o), 32'(!bus_a.bus_rd_nwr_o));
      if (prev_cs_n) check("cs_high_gap_ok", 32'(high_cnt >= A_S + A_H), 32'(1));
      high_cnt = 0;
    end else begin
      high_cnt++;
    end
    prev_snap = snap;
    prev_cs_n = bus_a.bus_cs_n_o;
  end

  // Scoreboard: every rsp_valid pulse pops the oldest expected response.
  always @(negedge clk) begin
    if (bus_a.rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid with data 0x%h, none outstanding (t=%0t)", bus_a.rsp_data_o, $time);
      end else begin
        check("rsp_data", 32'(bus_a.rsp_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic drive_cmd_a(input cmd_vec_t v);
    bus_a.cmd_wr_i      = v.wr;
    bus_a.cmd_byte_i    = v.byte_acc;
    bus_a.cmd_bytesel_i = v.bsel;
    bus_a.cmd_reg_i     = v.regn;
    bus_a.cmd_data_i    = v.data;
  endtask

  task automatic wait_ready_a(output bit ok);
    int n = 0;
    while (bus_a.cmd_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus_a.cmd_ready_o === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready_o stayed low for %0d cycles", n);
    end
  endtask

  task automatic wait_rsp_a(output int lat);
    lat = 1;
    while (bus_a.rsp_valid_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_cmd(input cmd_vec_t v, input string tag);
    int lat;
    bit ok;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    drive_cmd_a(v);
    bus_a.cmd_valid_i = 1'b1;
    exp_q.push_back(v.exp_rsp);
    wait_ready_a(ok);
    if (!ok) begin
      bus_a.cmd_valid_i = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid_i = 1'b0;
    wait_rsp_a(lat);
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
  endtask

  cmd_vec_t vecs[13];
  trace_t   trace_exp[1:9];

  initial begin
    int lat;
    int lows;
    int rsp_k;
    bit ok;
    cmd_vec_t c1, c2;

    bus_a.cmd_valid_i = 1'b0;
    drive_cmd_a('{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 0});
    bus_b.cmd_valid_i = 1'b0;
    bus_b.cmd_wr_i = 1'b0; bus_b.cmd_byte_i = 1'b0; bus_b.cmd_bytesel_i = 1'b0;
    bus_b.cmd_reg_i = 4'h0; bus_b.cmd_data_i = 16'h0000; bus_b.bus_data_i = 8'h00;

    // {wr, byte, bsel, reg, data, expected rsp_data, expected latency}; model starts with regB=1234, reg3=A55A after the trace
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'hB, 16'h0000, 16'h1234, 9};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h3, 16'h0000, 16'hA55A, 9};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'h5, 16'h00C7, 16'h0000, 5};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'h5, 16'h9900, 16'h0000, 5};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h5, 16'h0000, 16'h99C7, 9};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h3, 16'h0000, 16'hA500, 5};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'h3, 16'h0000, 16'h005A, 5};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'hF, 16'hFFFF, 16'h0000, 9};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 16'h00FF, 5};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h0001, 16'h0000, 9};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0001, 9};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'hB, 16'h56AB, 16'h0000, 5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'hB, 16'h0000, 16'h5634, 9};

    // word write reg3 A55A at S/T/H = 1/2/1: {cs_n, oe, rsp, rd_nwr, bsel, data} per cycle after accept
    trace_exp[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    trace_exp[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    trace_exp[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    trace_exp[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    trace_exp[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    trace_exp[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    trace_exp[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    trace_exp[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    trace_exp[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

    // reset values
    @(posedge clk);
    @(negedge clk);
    check("reset_bus", 32'({bus_a.bus_cs_n_o, bus_a.bus_rd_nwr_o, bus_a.bus_bytesel_o, bus_a.bus_reg_num_o,
                            bus_a.bus_data_o, bus_a.bus_data_oe_o}), 32'({1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0}));
    check("reset_ready", 32'(bus_a.cmd_ready_o), 32'(0));
    check("reset_rsp", 32'({bus_a.rsp_valid_o, bus_a.rsp_data_o}), 32'(0));
    check("reset_state", 32'(bus_a.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus_a.cmd_ready_o), 32'(1));

    // cycle-by-cycle word write
    drive_cmd_a('{1'b1, 1'b0, 1'b0, 4'h3, 16'hA55A, 16'h0000, 9});
    bus_a.cmd_valid_i = 1'b1;
    exp_q.push_back(16'h0000);
    wait_ready_a(ok);
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.cmd_valid_i = 1'b0;
      check($sformatf("trace_ctl_c%0d", k),
            32'({bus_a.bus_cs_n_o, bus_a.bus_data_oe_o, bus_a.rsp_valid_o, bus_a.bus_rd_nwr_o}),
            32'({trace_exp[k].cs_n, trace_exp[k].oe, trace_exp[k].rsp, trace_exp[k].rd_nwr}));
      if (k < 9)
        check($sformatf("trace_addr_c%0d", k),
              32'({bus_a.bus_reg_num_o, bus_a.bus_bytesel_o, bus_a.bus_data_o}),
              32'({4'h3, trace_exp[k].bsel, trace_exp[k].data}));
    end

    // command table against the register model
    foreach (vecs[i]) run_cmd(vecs[i], $sformatf("row%0d", i));

    // back-to-back: second command offered throughout and accepted in the rsp_valid cycle
    c1 = '{1'b1, 1'b0, 1'b0, 4'h2, 16'hBEEF, 16'h0000, 9};
    c2 = '{1'b0, 1'b0, 1'b0, 4'h2, 16'h0000, 16'hBEEF, 9};
    drive_cmd_a(c1);
    bus_a.cmd_valid_i = 1'b1;
    exp_q.push_back(c1.exp_rsp);
    exp_q.push_back(c2.exp_rsp);
    wait_ready_a(ok);
    @(posedge clk);
    @(negedge clk);
    drive_cmd_a(c2);
    wait_rsp_a(lat);
    check("b2b_lat1", 32'(lat), 32'(9));
    check("b2b_ready_in_rsp", 32'(bus_a.cmd_ready_o), 32'(1));
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid_i = 1'b0;
    wait_rsp_a(lat);
    check("b2b_lat2", 32'(lat), 32'(9));

    // reset in the second strobe cycle of a word write: first byte (13) already landed, no response
    drive_cmd_a('{1'b1, 1'b0, 1'b0, 4'h7, 16'h1357, 16'h0000, 9});
    bus_a.cmd_valid_i = 1'b1;
    wait_ready_a(ok);
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_cs", 32'(bus_a.bus_cs_n_o), 32'(0));
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_abort", 32'({bus_a.bus_cs_n_o, bus_a.bus_data_oe_o, bus_a.cmd_ready_o, bus_a.rsp_valid_o}),
          32'({1'b1, 1'b0, 1'b0, 1'b0}));
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_ready_back", 32'(bus_a.cmd_ready_o), 32'(1));
    run_cmd('{1'b0, 1'b0, 1'b0, 4'h7, 16'h0000, 16'h1300, 9}, "rst_read");

    // single-byte write on default 1/4/2 timing
    bus_b.cmd_wr_i = 1'b1; bus_b.cmd_byte_i = 1'b1; bus_b.cmd_bytesel_i = 1'b1;
    bus_b.cmd_reg_i = 4'h6; bus_b.cmd_data_i = 16'h00C7;
    bus_b.cmd_valid_i = 1'b1;
    for (int n = 0; n < 20 && bus_b.cmd_ready_o !== 1'b1; n++) @(negedge clk);
    @(posedge clk);
    lows = 0;
    rsp_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.cmd_valid_i = 1'b0;
      if (bus_b.bus_cs_n_o === 1'b0) begin
        lows++;
        check("b_strobe_addr", 32'({bus_b.bus_bytesel_o, bus_b.bus_data_o, bus_b.bus_data_oe_o, bus_b.bus_reg_num_o}),
              32'({1'b1, 8'hC7, 1'b1, 4'h6}));
      end
      if (bus_b.rsp_valid_o === 1'b1 && rsp_k == 0) begin
        rsp_k = k;
        check("b_rsp_data", 32'(bus_b.rsp_data_o), 32'(0));
      end
    end
    check("b_strobe_cycles", 32'(lows), 32'(4));
    check("b_rsp_cycle", 32'(rsp_k), 32'(8));

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
